// File: rtl/fp_expand_if.sv
// fp_expand_if: handshake bundle for the (S,E,F) -> linear expander.
// The producer/consumer side (master) drives the input word and out_ready.
// The expander itself uses the slave modport.
interface fp_expand_if #(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int FW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          in_s;
  logic [EW-1:0] in_e;
  logic [FW-1:0] in_f;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_d;

  modport master (
    output in_valid, in_s, in_e, in_f, out_ready,
    input  in_ready, out_valid, out_d
  );

  modport slave (
    input  in_valid, in_s, in_e, in_f, out_ready,
    output in_ready, out_valid, out_d
  );
endinterface

// File: rtl/fp_expand_seq.sv
// fp_expand_seq: rebuilds a DW-bit two's-complement value from an (S,E,F)
// word, D = (S ? -1 : 1) * (F << E). A single-bit-per-cycle shifter is used.
// Optional build macro FPDEC_HALF_LSB_EN: for E != 0 a half-LSB is appended
// so the result lands at the midpoint of the quantisation interval.
module fp_expand_seq #(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic         clk,
  input  logic         rst,
  fp_expand_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sign_bit;
  logic          sign_nxt;
  logic [DW-1:0] acc;
  logic [DW-1:0] acc_nxt;
  logic [EW-1:0] cnt;
  logic [EW-1:0] cnt_nxt;
  logic [DW-1:0] out_d_q;
  logic [DW-1:0] out_d_nxt;
  logic          out_valid_q;
  logic          out_valid_nxt;
  logic          in_ready_int;
  logic [FW-1:0] f_in;
  logic [EW-1:0] e_in;

  assign f_in          = bus.in_f;
  assign e_in          = bus.in_e;
  // Accept only while idle; a held reset keeps the input closed.
  assign in_ready_int  = (state == IDLE) && !rst;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_d     = out_d_q;

  // Next-state and datapath update for the accept/shift/sign/deliver sequence.
  always_comb begin
    state_nxt     = state;
    sign_nxt      = sign_bit;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    out_d_nxt     = out_d_q;
    out_valid_nxt = out_valid_q;
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_int) begin
          sign_nxt  = bus.in_s;
`ifdef FPDEC_HALF_LSB_EN
          // Appending a 1 below F and shifting one fewer time adds 1<<(E-1).
          if (e_in != {EW{1'b0}}) begin
            acc_nxt = DW'({f_in, 1'b1});
            cnt_nxt = e_in - EW'(1);
          end else begin
            acc_nxt = DW'(f_in);
            cnt_nxt = e_in;
          end
`else
          acc_nxt   = DW'(f_in);
          cnt_nxt   = e_in;
`endif
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cnt != {EW{1'b0}}) begin
          acc_nxt   = acc << 1;
          cnt_nxt   = cnt - EW'(1);
          state_nxt = SHIFT;
        end else begin
          state_nxt = SIGN;
        end
      end
      SIGN: begin
        // Negating zero gives zero, so no negative zero can appear.
        if (sign_bit) begin
          out_d_nxt = ~acc + DW'(1);
        end else begin
          out_d_nxt = acc;
        end
        out_valid_nxt = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          state_nxt     = DONE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_bit    <= 1'b0;
      acc         <= {DW{1'b0}};
      cnt         <= {EW{1'b0}};
      out_d_q     <= {DW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      sign_bit    <= sign_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      out_d_q     <= out_d_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fp_expand_seq.sv
// tb_fp_expand_seq: directed vectors with hand-computed results for
// fp_expand_seq, including back-pressure and mid-operation reset.
// Expected values follow FPDEC_HALF_LSB_EN when the macro is defined.
module tb_fp_expand_seq;

  localparam int DW = 12;
  localparam int EW = 3;
  localparam int FW = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fp_expand_if #(.DW(DW), .EW(EW), .FW(FW)) bus ();

  fp_expand_seq #(.DW(DW), .EW(EW), .FW(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one word for one cycle; it must be accepted on the next edge.
  task automatic send(input logic s, input logic [EW-1:0] e, input logic [FW-1:0] f);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_s     = s;
    bus.in_e     = e;
    bus.in_f     = f;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, then check the value.
  task automatic wait_out(input string tag, input logic [DW-1:0] exp_d, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 40);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_d"}, 32'(bus.out_d), 32'(exp_d));
  endtask

  // Complete the output handshake and confirm the block drops out_valid.
  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_clr", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_s      = 1'b0;
    bus.in_e      = 3'd0;
    bus.in_f      = 4'd0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_d", 32'(bus.out_d), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    // S=0,E=0,F=5: exact in both modes
    send(1'b0, 3'd0, 4'd5);
    wait_out("v1", 12'h005, 2);
    take();

`ifdef FPDEC_HALF_LSB_EN
    send(1'b0, 3'd7, 4'd15);  wait_out("v2", 12'h7C0, 8); take();
    send(1'b1, 3'd4, 4'd9);   wait_out("v3", 12'hF68, 5); take();
    send(1'b1, 3'd3, 4'd0);   wait_out("v4", 12'hFFC, 4); take();
    send(1'b1, 3'd0, 4'd15);  wait_out("v5", 12'hFF1, 2); take();
`else
    send(1'b0, 3'd7, 4'd15);  wait_out("v2", 12'h780, 9); take();
    send(1'b1, 3'd4, 4'd9);   wait_out("v3", 12'hF70, 6); take();
    send(1'b1, 3'd3, 4'd0);   wait_out("v4", 12'h000, 5); take();
    send(1'b1, 3'd0, 4'd15);  wait_out("v5", 12'hFF1, 2); take();
`endif

    // Back-pressure: hold in DONE for 5 cycles with a stray in_valid pulse.
    begin
      logic [DW-1:0] exp_bp;
`ifdef FPDEC_HALF_LSB_EN
      exp_bp = 12'h00E;
      send(1'b0, 3'd2, 4'd3);
      wait_out("bp", exp_bp, 3);
`else
      exp_bp = 12'h00C;
      send(1'b0, 3'd2, 4'd3);
      wait_out("bp", exp_bp, 4);
`endif
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_out_d", 32'(bus.out_d), 32'(exp_bp));
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = (i == 2);
        bus.in_s     = 1'b1;
        bus.in_e     = 3'd0;
        bus.in_f     = 4'd1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_out_d_hold", 32'(bus.out_d), 32'(exp_bp));
      take();
      @(negedge clk);
      check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
      repeat (4) @(negedge clk);
      check("bp_no_accept", 32'(bus.out_valid), 32'd0);
    end

    // Reset in the middle of a long shift.
    send(1'b0, 3'd6, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_d", 32'(bus.out_d), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
`ifdef FPDEC_HALF_LSB_EN
    send(1'b0, 3'd1, 4'd6);  wait_out("post_rst", 12'h00D, 2); take();
`else
    send(1'b0, 3'd1, 4'd6);  wait_out("post_rst", 12'h00C, 3); take();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
